// File: rtl/si_tag_converter_axis.sv
// AXI-Stream tag decoder: raw 32-bit tags plus wrap count in, absolute event time
// (1/3 ps), channel index and edge polarity out, with drop/filter statistics.
module si_tag_converter_axis #(
    parameter int CHANNEL_COUNT = 20,
    parameter int CHANNEL_WIDTH = 5,
    parameter int WRAP_WIDTH    = 32,
    parameter int TICK_LSB      = 4000,
    parameter int TIME_WIDTH    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [31:0]                s_axis_tdata,
    input  logic [WRAP_WIDTH-1:0]      wrap_count,
    input  logic [2*CHANNEL_COUNT-1:0] input_enable,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [TIME_WIDTH-1:0]      m_axis_ttime,
    output logic [CHANNEL_WIDTH-1:0]   m_axis_tchannel,
    output logic                       m_axis_trising,
    output logic [31:0]                invalid_count,
    output logic [31:0]                filtered_count
);

    localparam int RAW_COUNT = 2 * CHANNEL_COUNT;
    localparam int PROD_W    = WRAP_WIDTH + 12 + 13;
    localparam int EXT_W     = (PROD_W > TIME_WIDTH) ? PROD_W : TIME_WIDTH;

    // Full-width unsigned product, then zero-extended or truncated to the output width.
    function automatic logic [TIME_WIDTH-1:0] scale_ticks(
        input logic [WRAP_WIDTH-1:0] wrap,
        input logic [11:0]           cnt
    );
        logic [PROD_W-1:0] full;
        logic [EXT_W-1:0]  ext;
        full = PROD_W'({wrap, cnt}) * PROD_W'(TICK_LSB);
        ext  = EXT_W'(full);
        return ext[TIME_WIDTH-1:0];
    endfunction

    function automatic logic [TIME_WIDTH-1:0] add_subtime(
        input logic [TIME_WIDTH-1:0] prod,
        input logic [11:0]           sub
    );
        return prod + TIME_WIDTH'(sub);
    endfunction

    // Returns {rising, channel}.
    function automatic logic [CHANNEL_WIDTH:0] decode_channel(input logic [5:0] raw);
        if ({1'b0, raw} < 7'(CHANNEL_COUNT)) begin
            return {1'b1, CHANNEL_WIDTH'(raw)};
        end
        return {1'b0, CHANNEL_WIDTH'(raw - 6'(CHANNEL_COUNT))};
    endfunction

    logic [1:0]  tag_type;
    logic [5:0]  tag_raw;
    logic [11:0] tag_sub;
    logic [11:0] tag_cnt;
    logic        tag_legal;
    logic        tag_en;
    logic        accept;
    logic        adv;

    assign tag_type = s_axis_tdata[31:30];
    assign tag_raw  = s_axis_tdata[29:24];
    assign tag_sub  = s_axis_tdata[23:12];
    assign tag_cnt  = s_axis_tdata[11:0];

    assign adv           = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = adv && !rst;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign tag_legal     = (tag_type == 2'b01) && ({1'b0, tag_raw} < 7'(RAW_COUNT));

    always_comb begin
        tag_en = 1'b0;
        for (int i = 0; i < RAW_COUNT; i++) begin
            if (tag_raw == 6'(i)) begin
                tag_en = input_enable[i];
            end
        end
    end

    logic                     vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q, vld_p5_q;
    logic                     vld_p1_d;
    logic [TIME_WIDTH-1:0]    prod_p1_d;
    logic [TIME_WIDTH-1:0]    prod_p1_q, prod_p2_q, prod_p3_q, prod_p4_q;
    logic [11:0]              sub_p1_q, sub_p2_q, sub_p3_q, sub_p4_q;
    logic [5:0]               raw_p1_q, raw_p2_q, raw_p3_q, raw_p4_q;
    logic [TIME_WIDTH-1:0]    time_p5_d, time_p5_q;
    logic [CHANNEL_WIDTH-1:0] chan_p5_d, chan_p5_q;
    logic                     rise_p5_d, rise_p5_q;
    logic [31:0]              invalid_d, invalid_q;
    logic [31:0]              filtered_d, filtered_q;

    // Stage 1: classify and start the time multiply
    always_comb begin
        vld_p1_d   = accept && tag_legal && tag_en;
        prod_p1_d  = scale_ticks(wrap_count, tag_cnt);
        invalid_d  = invalid_q + 32'(accept && !tag_legal);
        filtered_d = filtered_q + 32'(accept && tag_legal && !tag_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            vld_p3_q   <= 1'b0;
            vld_p4_q   <= 1'b0;
            vld_p5_q   <= 1'b0;
            invalid_q  <= '0;
            filtered_q <= '0;
        end else begin
            invalid_q  <= invalid_d;
            filtered_q <= filtered_d;
            if (adv) begin
                vld_p1_q <= vld_p1_d;
                vld_p2_q <= vld_p1_q;
                vld_p3_q <= vld_p2_q;
                vld_p4_q <= vld_p3_q;
                vld_p5_q <= vld_p4_q;
            end
        end
    end

    // Stages 1-4: data carried alongside the valids; retiming room for the multiplier
    always_ff @(posedge clk) begin
        if (adv) begin
            prod_p1_q <= prod_p1_d;
            sub_p1_q  <= tag_sub;
            raw_p1_q  <= tag_raw;
            prod_p2_q <= prod_p1_q;
            sub_p2_q  <= sub_p1_q;
            raw_p2_q  <= raw_p1_q;
            prod_p3_q <= prod_p2_q;
            sub_p3_q  <= sub_p2_q;
            raw_p3_q  <= raw_p2_q;
            prod_p4_q <= prod_p3_q;
            sub_p4_q  <= sub_p3_q;
            raw_p4_q  <= raw_p3_q;
        end
    end

    // Stage 5: final time sum and edge decode, registered straight onto the outputs
    always_comb begin
        time_p5_d              = add_subtime(prod_p4_q, sub_p4_q);
        {rise_p5_d, chan_p5_d} = decode_channel(raw_p4_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_p5_q <= '0;
            chan_p5_q <= '0;
            rise_p5_q <= 1'b0;
        end else if (adv) begin
            time_p5_q <= time_p5_d;
            chan_p5_q <= chan_p5_d;
            rise_p5_q <= rise_p5_d;
        end
    end

    assign m_axis_tvalid   = vld_p5_q;
    assign m_axis_ttime    = time_p5_q;
    assign m_axis_tchannel = chan_p5_q;
    assign m_axis_trising  = rise_p5_q;
    assign invalid_count   = invalid_q;
    assign filtered_count  = filtered_q;

endmodule

// File: tb/tb_si_tag_converter_axis.sv
// Bench for si_tag_converter_axis: directed decode/filter/reset scenarios plus randomized
// traffic under backpressure, compared against a spec-level event model.
`timescale 1ns/1ps
module tb_si_tag_converter_axis;

    localparam int CC = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [31:0] wrap_count;
    logic [39:0] input_enable;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_ttime;
    logic [4:0]  m_axis_tchannel;
    logic        m_axis_trising;
    logic [31:0] invalid_count;
    logic [31:0] filtered_count;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [63:0] t;
        logic [4:0]  ch;
        logic        r;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int unsigned exp_invalid = 0;
    int unsigned exp_filtered = 0;

    always #5 clk = ~clk;

    si_tag_converter_axis #(
        .CHANNEL_COUNT(CC), .CHANNEL_WIDTH(5), .WRAP_WIDTH(32), .TICK_LSB(4000), .TIME_WIDTH(64)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .wrap_count(wrap_count), .input_enable(input_enable),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_ttime(m_axis_ttime), .m_axis_tchannel(m_axis_tchannel),
        .m_axis_trising(m_axis_trising),
        .invalid_count(invalid_count), .filtered_count(filtered_count)
    );

    // Reference model: decode one accepted tag from the field definitions.
    function automatic void model_accept(input logic [31:0] tag, input logic [31:0] w,
                                         input logic [39:0] en);
        int unsigned ty  = tag[31:30];
        int unsigned raw = tag[29:24];
        logic [63:0] ticks;
        ev_t e;
        if (ty != 1 || raw >= 2 * CC) begin
            exp_invalid++;
        end else if (!en[raw]) begin
            exp_filtered++;
        end else begin
            ticks = {32'd0, w} * 64'd4096 + 64'(tag[11:0]);
            e.t   = ticks * 64'd4000 + 64'(tag[23:12]);
            if (raw < CC) begin
                e.ch = 5'(raw);
                e.r  = 1'b1;
            end else begin
                e.ch = 5'(raw - CC);
                e.r  = 1'b0;
            end
            exp_q.push_back(e);
        end
    endfunction

    // Handshakes are observed on the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        ev_t o;
        if (rst) begin
            exp_q.delete();
            exp_invalid  = 0;
            exp_filtered = 0;
        end else begin
            if (s_axis_tvalid && s_axis_tready) model_accept(s_axis_tdata, wrap_count, input_enable);
            if (m_axis_tvalid && m_axis_tready) begin
                o.t  = m_axis_ttime;
                o.ch = m_axis_tchannel;
                o.r  = m_axis_trising;
                obs_q.push_back(o);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] t, input logic [31:0] w);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = t;
        wrap_count    = w;
        @(negedge clk);
        while (!s_axis_tready && n < 50) begin
            tick();
            @(negedge clk);
            n++;
        end
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (s_axis_tready !== 1'b0) $display("FAIL rst_tready: got %b want 0", s_axis_tready); else passed++;
        checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); else passed++;
        checks++; if (m_axis_ttime !== 64'd0) $display("FAIL rst_time: got %0d want 0", m_axis_ttime); else passed++;
        checks++; if ({m_axis_tchannel, m_axis_trising} !== 6'd0) $display("FAIL rst_chan: got %0d/%b want 0/0", m_axis_tchannel, m_axis_trising); else passed++;
        checks++; if (invalid_count !== 32'd0 || filtered_count !== 32'd0) $display("FAIL rst_counters: got %0d/%0d want 0/0", invalid_count, filtered_count); else passed++;
        rst = 1'b0;
        tick();
        checks++; if (s_axis_tready !== 1'b1) $display("FAIL post_rst_tready: got %b want 1", s_axis_tready); else passed++;
    endtask

    task automatic test_rising_decode();
        int lat = 0;
        logic [63:0] t_seen = '0;
        logic [5:0]  c_seen = '0;
        drain(); obs_q.delete(); exp_q.delete();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h4152_3007;
        wrap_count    = 32'd2;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (k == 1) s_axis_tvalid = 1'b0;
            if (m_axis_tvalid) begin
                lat    = k;
                t_seen = m_axis_ttime;
                c_seen = {m_axis_tchannel, m_axis_trising};
            end
        end
        checks++; if (lat !== 5) $display("FAIL rise_latency: got %0d want 5", lat); else passed++;
        checks++; if (t_seen !== 64'd32797315) $display("FAIL rise_time: got %0d want 32797315", t_seen); else passed++;
        checks++; if (c_seen !== {5'd1, 1'b1}) $display("FAIL rise_chan: got ch=%0d r=%b want ch=1 r=1", c_seen[5:1], c_seen[0]); else passed++;
    endtask

    task automatic test_falling_decode();
        logic [31:0] i0, f0;
        ev_t o;
        drain(); obs_q.delete(); exp_q.delete();
        i0 = invalid_count; f0 = filtered_count;
        send(32'h5500_0000, 32'd0);
        send(32'h6800_0000, 32'd0);
        drain();
        o = (obs_q.size() > 0) ? obs_q[0] : '1;
        checks++; if (obs_q.size() !== 1) $display("FAIL fall_count: got %0d want 1", obs_q.size()); else passed++;
        checks++; if (o !== {64'd0, 5'd1, 1'b0}) $display("FAIL fall_event: got t=%0d ch=%0d r=%b want t=0 ch=1 r=0", o.t, o.ch, o.r); else passed++;
        checks++; if (invalid_count - i0 !== 32'd1) $display("FAIL fall_invalid: got %0d want 1", invalid_count - i0); else passed++;
        checks++; if (filtered_count - f0 !== 32'd0) $display("FAIL fall_filtered: got %0d want 0", filtered_count - f0); else passed++;
    endtask

    task automatic test_type_filter();
        logic [31:0] i0, f0;
        drain(); obs_q.delete(); exp_q.delete();
        i0 = invalid_count; f0 = filtered_count;
        send(32'h0312_3456, 32'd1);
        send(32'h8312_3456, 32'd1);
        send(32'hC312_3456, 32'd1);
        drain();
        checks++; if (obs_q.size() !== 0) $display("FAIL type_output: got %0d events want 0", obs_q.size()); else passed++;
        checks++; if (invalid_count - i0 !== 32'd3) $display("FAIL type_invalid: got %0d want 3", invalid_count - i0); else passed++;
        checks++; if (filtered_count - f0 !== 32'd0) $display("FAIL type_filtered: got %0d want 0", filtered_count - f0); else passed++;
    endtask

    task automatic test_enable_mask();
        logic [31:0] i0, f0;
        drain(); obs_q.delete(); exp_q.delete();
        i0 = invalid_count; f0 = filtered_count;
        input_enable = ~(40'd1 << 5);
        for (int k = 1; k <= 4; k++) begin
            send(32'h4500_0000 + 32'(k), 32'd0);
            send(32'h4600_0000 + 32'(k), 32'd0);
        end
        drain();
        input_enable = '1;
        checks++; if (obs_q.size() !== 4) $display("FAIL mask_count: got %0d want 4", obs_q.size()); else passed++;
        for (int k = 1; k <= 4 && k <= obs_q.size(); k++) begin
            checks++;
            if (obs_q[k-1] !== {64'(k * 4000), 5'd6, 1'b1})
                $display("FAIL mask_event%0d: got t=%0d ch=%0d r=%b want t=%0d ch=6 r=1", k, obs_q[k-1].t, obs_q[k-1].ch, obs_q[k-1].r, k * 4000);
            else passed++;
        end
        checks++; if (filtered_count - f0 !== 32'd4) $display("FAIL mask_filtered: got %0d want 4", filtered_count - f0); else passed++;
        checks++; if (invalid_count - i0 !== 32'd0) $display("FAIL mask_invalid: got %0d want 0", invalid_count - i0); else passed++;
    endtask

    task automatic test_time_max();
        ev_t o;
        drain(); obs_q.delete(); exp_q.delete();
        send(32'h40FF_FFFF, 32'hFFFF_FFFF);
        drain();
        o = (obs_q.size() > 0) ? obs_q[0] : '0;
        checks++;
        if (o !== {64'd70368744177664095, 5'd0, 1'b1})
            $display("FAIL max_time: got t=%0d ch=%0d r=%b want t=70368744177664095 ch=0 r=1", o.t, o.ch, o.r);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] bp_tag[16];
        logic [31:0] bp_wrap[16];
        int          idx = 0;
        logic        stalled = 1'b0;
        logic [70:0] hold = '0;
        drain(); obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            bp_tag[i]  = {2'b01, 6'($urandom_range(0, 2 * CC - 1)), 12'($urandom), 12'(i)};
            bp_wrap[i] = $urandom;
        end
        for (int c = 0; c < 400; c++) begin
            if (idx == 16 && obs_q.size() == 16) break;
            tick();
            if (stalled) begin
                checks++;
                if ({m_axis_tvalid, m_axis_ttime, m_axis_tchannel, m_axis_trising} !== hold)
                    $display("FAIL bp_stable c%0d: got %h want %h", c, {m_axis_tvalid, m_axis_ttime, m_axis_tchannel, m_axis_trising}, hold);
                else passed++;
            end
            m_axis_tready = (c >= 6 && c < 16) ? 1'b0 : 1'($urandom_range(0, 1));
            s_axis_tvalid = (idx < 16);
            if (idx < 16) begin
                s_axis_tdata = bp_tag[idx];
                wrap_count   = bp_wrap[idx];
            end
            #1;
            checks++;
            if (s_axis_tready !== !(m_axis_tvalid && !m_axis_tready))
                $display("FAIL bp_tready c%0d: got %b want %b", c, s_axis_tready, !(m_axis_tvalid && !m_axis_tready));
            else passed++;
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) idx++;
            stalled = m_axis_tvalid && !m_axis_tready;
            hold    = {m_axis_tvalid, m_axis_ttime, m_axis_tchannel, m_axis_trising};
        end
        tick();
        s_axis_tvalid = 1'b0;
        checks++; if (idx !== 16) $display("FAIL bp_sent: got %0d want 16", idx); else passed++;
        drain();
        checks++; if (obs_q.size() !== 16 || exp_q.size() !== 16) $display("FAIL bp_count: got %0d want %0d (16 sent)", obs_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL bp_event%0d: got t=%0d ch=%0d r=%b want t=%0d ch=%0d r=%b", i, obs_q[i].t, obs_q[i].ch, obs_q[i].r, exp_q[i].t, exp_q[i].ch, exp_q[i].r);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic pend = 1'b0;
        int   n_sent = 0;
        drain(); obs_q.delete(); exp_q.delete();
        for (int c = 0; c < 300; c++) begin
            tick();
            m_axis_tready = ($urandom_range(0, 3) != 0);
            input_enable  = 40'({$urandom, $urandom}) | 40'({$urandom, $urandom});
            if (!pend && n_sent < 60 && $urandom_range(0, 3) != 0) begin
                s_axis_tdata = {($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01,
                                6'($urandom_range(0, 47)), 12'($urandom), 12'($urandom)};
                wrap_count   = $urandom;
                pend         = 1'b1;
                n_sent++;
            end
            s_axis_tvalid = pend;
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) pend = 1'b0;
        end
        tick();
        drain();
        input_enable = '1;
        checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL rnd_event%0d: got t=%0d ch=%0d r=%b want t=%0d ch=%0d r=%b", i, obs_q[i].t, obs_q[i].ch, obs_q[i].r, exp_q[i].t, exp_q[i].ch, exp_q[i].r);
            else passed++;
        end
        checks++; if (invalid_count !== 32'(exp_invalid)) $display("FAIL rnd_invalid: got %0d want %0d", invalid_count, exp_invalid); else passed++;
        checks++; if (filtered_count !== 32'(exp_filtered)) $display("FAIL rnd_filtered: got %0d want %0d", filtered_count, exp_filtered); else passed++;
    endtask

    task automatic test_reset_midstream();
        int lat = 0;
        logic [63:0] t_seen = '0;
        drain(); obs_q.delete(); exp_q.delete();
        m_axis_tready = 1'b0;
        send(32'h0000_0000, 32'd0);
        send(32'h4100_0001, 32'd0);
        send(32'h4200_0002, 32'd0);
        send(32'h4300_0003, 32'd0);
        repeat (4) tick();
        checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL mid_stalled: got tvalid %b want 1", m_axis_tvalid); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (s_axis_tready !== 1'b0) $display("FAIL mid_rst_tready: got %b want 0", s_axis_tready); else passed++;
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({m_axis_tvalid, m_axis_ttime} !== 65'd0) $display("FAIL mid_out_cleared: got v=%b t=%0d want 0", m_axis_tvalid, m_axis_ttime); else passed++;
        checks++; if (invalid_count !== 32'd0 || filtered_count !== 32'd0) $display("FAIL mid_counters: got %0d/%0d want 0/0", invalid_count, filtered_count); else passed++;
        m_axis_tready = 1'b1;
        repeat (8) tick();
        checks++; if (obs_q.size() !== 0) $display("FAIL mid_stale: got %0d events want 0", obs_q.size()); else passed++;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h4152_3007;
        wrap_count    = 32'd2;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (k == 1) s_axis_tvalid = 1'b0;
            if (m_axis_tvalid) begin
                lat    = k;
                t_seen = m_axis_ttime;
            end
        end
        checks++; if (lat !== 5) $display("FAIL mid_latency: got %0d want 5", lat); else passed++;
        checks++; if (t_seen !== 64'd32797315) $display("FAIL mid_time: got %0d want 32797315", t_seen); else passed++;
        drain();
        checks++; if (obs_q.size() !== 1) $display("FAIL mid_count: got %0d want 1", obs_q.size()); else passed++;
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        wrap_count    = '0;
        input_enable  = '1;
        m_axis_tready = 1'b1;
        test_reset();
        test_rising_decode();
        test_falling_decode();
        test_type_filter();
        test_enable_mask();
        test_time_max();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
